// File: rtl/ex_mem_skid_if.sv
// Handshake and payload bundle between the EX stage, the EX/MEM skid buffer and the MEM stage.
// The slave modport is the buffer's view; the master modport is the surrounding pipeline's view.
interface ex_mem_skid_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              flush_i;
  logic              ex_valid_i;
  logic              ex_ready_o;
  logic [ADDR_W-1:0] ex_wd_i;
  logic              ex_wreg_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              mem_valid_o;
  logic              mem_ready_i;
  logic [ADDR_W-1:0] mem_wd_o;
  logic              mem_wreg_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [ADDR_W-1:0] fwd_wd_o;
  logic              fwd_wreg_o;
  logic [DATA_W-1:0] fwd_wdata_o;
  logic [1:0]        count_o;

  modport slave (
    input  flush_i, ex_valid_i, ex_wd_i, ex_wreg_i, ex_wdata_i, mem_ready_i,
    output ex_ready_o, mem_valid_o, mem_wd_o, mem_wreg_o, mem_wdata_o,
           fwd_wd_o, fwd_wreg_o, fwd_wdata_o, count_o
  );

  modport master (
    output flush_i, ex_valid_i, ex_wd_i, ex_wreg_i, ex_wdata_i, mem_ready_i,
    input  ex_ready_o, mem_valid_o, mem_wd_o, mem_wreg_o, mem_wdata_o,
           fwd_wd_o, fwd_wreg_o, fwd_wdata_o, count_o
  );
endinterface

// File: rtl/ex_mem_skid.sv
// Two-entry EX/MEM pipeline register: a head register drives MEM, a skid register absorbs one
// beat of backpressure so that ex_ready_o never depends combinationally on mem_ready_i.
module ex_mem_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic          clk,
  input logic          rst,
  ex_mem_skid_if.slave bus
);

  logic              head_valid_r, head_valid_s;
  logic [ADDR_W-1:0] head_wd_r,    head_wd_s;
  logic              head_wreg_r,  head_wreg_s;
  logic [DATA_W-1:0] head_wdata_r, head_wdata_s;
  logic              skid_valid_r, skid_valid_s;
  logic [ADDR_W-1:0] skid_wd_r,    skid_wd_s;
  logic              skid_wreg_r,  skid_wreg_s;
  logic [DATA_W-1:0] skid_wdata_r, skid_wdata_s;
  logic              ready_r;
  logic              fwd_wreg_r;
  logic [1:0]        count_r;
  logic              accept_s;
  logic              drain_s;

  assign accept_s = bus.ex_valid_i & ready_r;
  assign drain_s  = head_valid_r & bus.mem_ready_i;

  // Next-state of both entries from the accept/drain combination; flush only drops the valid flags.
  always_comb begin
    head_valid_s = head_valid_r;
    head_wd_s    = head_wd_r;
    head_wreg_s  = head_wreg_r;
    head_wdata_s = head_wdata_r;
    skid_valid_s = skid_valid_r;
    skid_wd_s    = skid_wd_r;
    skid_wreg_s  = skid_wreg_r;
    skid_wdata_s = skid_wdata_r;
    if (bus.flush_i) begin
      head_valid_s = 1'b0;
      skid_valid_s = 1'b0;
    end else begin
      case ({skid_valid_r, head_valid_r})
        2'b00: begin
          if (accept_s) begin
            head_valid_s = 1'b1;
            head_wd_s    = bus.ex_wd_i;
            head_wreg_s  = bus.ex_wreg_i;
            head_wdata_s = bus.ex_wdata_i;
          end else begin
            head_valid_s = 1'b0;
          end
        end
        2'b01: begin
          if (accept_s && drain_s) begin
            head_wd_s    = bus.ex_wd_i;
            head_wreg_s  = bus.ex_wreg_i;
            head_wdata_s = bus.ex_wdata_i;
          end else if (accept_s) begin
            skid_valid_s = 1'b1;
            skid_wd_s    = bus.ex_wd_i;
            skid_wreg_s  = bus.ex_wreg_i;
            skid_wdata_s = bus.ex_wdata_i;
          end else if (drain_s) begin
            head_valid_s = 1'b0;
          end else begin
            head_valid_s = 1'b1;
          end
        end
        2'b11: begin
          // Skid full means ready was low, so no accept can coincide with the move.
          if (drain_s) begin
            skid_valid_s = 1'b0;
            head_wd_s    = skid_wd_r;
            head_wreg_s  = skid_wreg_r;
            head_wdata_s = skid_wdata_r;
          end else begin
            skid_valid_s = 1'b1;
          end
        end
        default: begin
          head_valid_s = 1'b0;
          skid_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State registers; ready, forward-wreg and count are registered copies of next-state terms.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid_r <= 1'b0;
      head_wd_r    <= {ADDR_W{1'b0}};
      head_wreg_r  <= 1'b0;
      head_wdata_r <= {DATA_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_wd_r    <= {ADDR_W{1'b0}};
      skid_wreg_r  <= 1'b0;
      skid_wdata_r <= {DATA_W{1'b0}};
      ready_r      <= 1'b1;
      fwd_wreg_r   <= 1'b0;
      count_r      <= 2'd0;
    end else begin
      head_valid_r <= head_valid_s;
      head_wd_r    <= head_wd_s;
      head_wreg_r  <= head_wreg_s;
      head_wdata_r <= head_wdata_s;
      skid_valid_r <= skid_valid_s;
      skid_wd_r    <= skid_wd_s;
      skid_wreg_r  <= skid_wreg_s;
      skid_wdata_r <= skid_wdata_s;
      ready_r      <= ~skid_valid_s;
      fwd_wreg_r   <= head_valid_s & head_wreg_s;
      count_r      <= {1'b0, head_valid_s} + {1'b0, skid_valid_s};
    end
  end

  assign bus.ex_ready_o  = ready_r;
  assign bus.mem_valid_o = head_valid_r;
  assign bus.mem_wd_o    = head_wd_r;
  assign bus.mem_wreg_o  = head_wreg_r;
  assign bus.mem_wdata_o = head_wdata_r;
  assign bus.fwd_wd_o    = head_wd_r;
  assign bus.fwd_wreg_o  = fwd_wreg_r;
  assign bus.fwd_wdata_o = head_wdata_r;
  assign bus.count_o     = count_r;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid: reset, single beat, backpressure, streaming, flush, bubble and
// mid-operation reset, each with hand-computed expectations checked by immediate assertions.
module tb_ex_mem_skid;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  ex_mem_skid_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  ex_mem_skid #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic [4:0] wd, input logic wreg, input logic [31:0] data);
    bus.ex_valid_i = 1'b1;
    bus.ex_wd_i    = wd;
    bus.ex_wreg_i  = wreg;
    bus.ex_wdata_i = data;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.flush_i     = 1'b0;
    bus.ex_valid_i  = 1'b0;
    bus.ex_wd_i     = 5'd0;
    bus.ex_wreg_i   = 1'b0;
    bus.ex_wdata_i  = 32'd0;
    bus.mem_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid", {31'd0, bus.mem_valid_o}, 32'd0);
    chk("rst_wd", {27'd0, bus.mem_wd_o}, 32'd0);
    chk("rst_wreg", {31'd0, bus.mem_wreg_o}, 32'd0);
    chk("rst_wdata", bus.mem_wdata_o, 32'd0);
    chk("rst_fwd_wd", {27'd0, bus.fwd_wd_o}, 32'd0);
    chk("rst_fwd_wreg", {31'd0, bus.fwd_wreg_o}, 32'd0);
    chk("rst_fwd_wdata", bus.fwd_wdata_o, 32'd0);
    chk("rst_count", {30'd0, bus.count_o}, 32'd0);
    chk("rst_ready", {31'd0, bus.ex_ready_o}, 32'd1);

    // Single beat with MEM always ready
    bus.mem_ready_i = 1'b1;
    beat(5'd3, 1'b1, 32'h0000_00FF);
    tick();
    bus.ex_valid_i = 1'b0;
    chk("single_valid", {31'd0, bus.mem_valid_o}, 32'd1);
    chk("single_wd", {27'd0, bus.mem_wd_o}, 32'd3);
    chk("single_wdata", bus.mem_wdata_o, 32'hFF);
    chk("single_fwd_wreg", {31'd0, bus.fwd_wreg_o}, 32'd1);
    chk("single_fwd_wdata", bus.fwd_wdata_o, 32'hFF);
    chk("single_count", {30'd0, bus.count_o}, 32'd1);
    tick();
    chk("single_gone", {31'd0, bus.mem_valid_o}, 32'd0);
    chk("single_gone_cnt", {30'd0, bus.count_o}, 32'd0);

    // Backpressure fills head then skid
    bus.mem_ready_i = 1'b0;
    beat(5'd1, 1'b1, 32'h11);
    tick();
    chk("bp_ready_one", {31'd0, bus.ex_ready_o}, 32'd1);
    beat(5'd2, 1'b1, 32'h22);
    tick();
    bus.ex_valid_i = 1'b0;
    chk("bp_count", {30'd0, bus.count_o}, 32'd2);
    chk("bp_ready", {31'd0, bus.ex_ready_o}, 32'd0);
    chk("bp_head", bus.mem_wdata_o, 32'h11);
    tick();
    chk("bp_hold", bus.mem_wdata_o, 32'h11);
    chk("bp_hold_cnt", {30'd0, bus.count_o}, 32'd2);
    bus.mem_ready_i = 1'b1;
    tick();
    chk("bp_second", bus.mem_wdata_o, 32'h22);
    chk("bp_second_wd", {27'd0, bus.mem_wd_o}, 32'd2);
    chk("bp_second_cnt", {30'd0, bus.count_o}, 32'd1);
    chk("bp_ready_back", {31'd0, bus.ex_ready_o}, 32'd1);
    tick();
    chk("bp_empty", {31'd0, bus.mem_valid_o}, 32'd0);

    // Streaming: accept and drain every cycle
    for (int i = 1; i <= 8; i++) begin
      beat(5'(i), 1'b1, 32'(i));
      tick();
      chk("stream_data", bus.mem_wdata_o, 32'(i));
      chk("stream_valid", {31'd0, bus.mem_valid_o}, 32'd1);
      chk("stream_count", {30'd0, bus.count_o}, 32'd1);
      chk("stream_ready", {31'd0, bus.ex_ready_o}, 32'd1);
    end
    bus.ex_valid_i = 1'b0;
    tick();
    chk("stream_end", {31'd0, bus.mem_valid_o}, 32'd0);

    // Flush with two beats held and a beat offered
    bus.mem_ready_i = 1'b0;
    beat(5'd4, 1'b1, 32'h44);
    tick();
    beat(5'd5, 1'b1, 32'h55);
    tick();
    chk("fl_count_pre", {30'd0, bus.count_o}, 32'd2);
    beat(5'd6, 1'b1, 32'h33);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.ex_valid_i = 1'b0;
    chk("fl_count", {30'd0, bus.count_o}, 32'd0);
    chk("fl_valid", {31'd0, bus.mem_valid_o}, 32'd0);
    chk("fl_ready", {31'd0, bus.ex_ready_o}, 32'd1);
    bus.mem_ready_i = 1'b1;
    tick();
    chk("fl_no33", {31'd0, bus.mem_valid_o}, 32'd0);

    // Flush overrides a same-cycle accept while ready is high
    beat(5'd8, 1'b1, 32'h66);
    tick();
    chk("fl2_pre", {30'd0, bus.count_o}, 32'd1);
    bus.mem_ready_i = 1'b0;
    beat(5'd9, 1'b1, 32'h77);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.ex_valid_i = 1'b0;
    chk("fl2_count", {30'd0, bus.count_o}, 32'd0);
    chk("fl2_fwd_wreg", {31'd0, bus.fwd_wreg_o}, 32'd0);

    // Bubble beat with wreg=0 is still carried
    beat(5'd7, 1'b0, 32'h5);
    tick();
    bus.ex_valid_i = 1'b0;
    chk("bub_valid", {31'd0, bus.mem_valid_o}, 32'd1);
    chk("bub_wreg", {31'd0, bus.mem_wreg_o}, 32'd0);
    chk("bub_fwd_wreg", {31'd0, bus.fwd_wreg_o}, 32'd0);
    chk("bub_wd", {27'd0, bus.mem_wd_o}, 32'd7);
    chk("bub_fwd_wd", {27'd0, bus.fwd_wd_o}, 32'd7);
    chk("bub_wdata", bus.mem_wdata_o, 32'h5);
    bus.mem_ready_i = 1'b1;
    tick();
    chk("bub_drained", {30'd0, bus.count_o}, 32'd0);

    // Reset while two beats are held and a handshake is in flight
    bus.mem_ready_i = 1'b0;
    beat(5'd10, 1'b1, 32'hAA);
    tick();
    beat(5'd11, 1'b1, 32'hBB);
    tick();
    chk("rm_count_pre", {30'd0, bus.count_o}, 32'd2);
    beat(5'd12, 1'b1, 32'hCC);
    bus.mem_ready_i = 1'b1;
    bus.flush_i = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.flush_i = 1'b0;
    bus.ex_valid_i = 1'b0;
    chk("rm_valid", {31'd0, bus.mem_valid_o}, 32'd0);
    chk("rm_wd", {27'd0, bus.mem_wd_o}, 32'd0);
    chk("rm_wreg", {31'd0, bus.mem_wreg_o}, 32'd0);
    chk("rm_wdata", bus.mem_wdata_o, 32'd0);
    chk("rm_fwd_wdata", bus.fwd_wdata_o, 32'd0);
    chk("rm_fwd_wreg", {31'd0, bus.fwd_wreg_o}, 32'd0);
    chk("rm_count", {30'd0, bus.count_o}, 32'd0);
    chk("rm_ready", {31'd0, bus.ex_ready_o}, 32'd1);
    tick();
    chk("rm_no_emit", {31'd0, bus.mem_valid_o}, 32'd0);
    tick();
    chk("rm_no_emit2", {31'd0, bus.mem_valid_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of the result data.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning the width of the register-file write address.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port flush_i  input  1  discards all held beats.
REQ-006 The block SHALL have port ex_valid_i  input  1  EX presents a result beat.
REQ-007 The block SHALL have port ex_ready_o  output  1  block can accept a beat this cycle.
REQ-008 The block SHALL have port ex_wd_i  input  ADDR_W  EX destination register address.
REQ-009 The block SHALL have port ex_wreg_i  input  1  EX write-enable flag.
REQ-010 The block SHALL have port ex_wdata_i  input  DATA_W  EX result data.
REQ-011 The block SHALL have port mem_valid_o  output  1  MEM-side beat valid.
REQ-012 The block SHALL have port mem_ready_i  input  1  MEM stage accepts the beat.
REQ-013 The block SHALL have ports mem_wd_o, mem_wreg_o, mem_wdata_o  output  ADDR_W/1/DATA_W  head beat fields.
REQ-014 The block SHALL have ports fwd_wd_o, fwd_wreg_o, fwd_wdata_o  output  ADDR_W/1/DATA_W  forwarding view of the head beat.
REQ-015 The block SHALL have port count_o  output  2  number of held beats (0..2).

Function
REQ-016 Storage SHALL be a head register driving mem_* and one skid register; each has a valid flag.
REQ-017 ex_ready_o SHALL equal NOT skid_valid, driven from a register only (no combinational path from mem_ready_i).
REQ-018 Accept SHALL occur when ex_valid_i AND ex_ready_o; drain SHALL occur when mem_valid_o AND mem_ready_i.
REQ-019 mem_valid_o SHALL equal head_valid; mem_* fields SHALL be the head register contents.
REQ-020 Empty head + accept: beat SHALL load into head; appears on mem_* the next cycle (latency 1).
REQ-021 Head valid, accept and drain together: new beat SHALL load into head; skid stays empty.
REQ-022 Head valid, accept, no drain: new beat SHALL load into skid; ex_ready_o falls the next cycle.
REQ-023 Skid valid and drain: skid SHALL move into head, skid_valid clears, ex_ready_o rises next cycle.
REQ-024 Head valid, drain, no accept, skid empty: head_valid SHALL clear.
REQ-025 Beats SHALL leave in acceptance order; none dropped or duplicated except by flush/reset.
REQ-026 A beat with ex_wreg_i=0 SHALL still be a valid beat carried unmodified.
REQ-027 flush_i SHALL clear head_valid and skid_valid next cycle, overriding any same-cycle accept or drain.
REQ-028 fwd_wd_o/fwd_wdata_o SHALL mirror the head fields; fwd_wreg_o SHALL equal head_valid AND head wreg.
REQ-029 count_o SHALL equal head_valid + skid_valid; the value 3 SHALL never occur.
REQ-030 Data registers SHALL load only on their accept/move event; otherwise hold.

Reset
REQ-031 During rst all valid flags SHALL be 0 and all data fields 0 on the next edge.
REQ-032 After reset: mem_valid_o=0, mem_wd_o=0, mem_wreg_o=0, mem_wdata_o=0, fwd_*=0, count_o=0, ex_ready_o=1.
REQ-033 rst SHALL override flush_i and any in-flight handshake; held beats are discarded.

Verification
REQ-034 Single beat: wd=3,wreg=1,wdata=0x0000_00FF, mem_ready_i=1 -> next cycle mem_valid_o=1, mem_wd_o=3, mem_wdata_o=0xFF, fwd_wreg_o=1; following cycle mem_valid_o=0.
REQ-035 Backpressure: mem_ready_i=0, beats A=0x11, B=0x22 on consecutive cycles -> count_o=2, ex_ready_o=0, mem_wdata_o=0x11; mem_ready_i=1 -> 0x11 then 0x22 in order, ex_ready_o=1 after skid drains.
REQ-036 Streaming: ex_valid_i=1, mem_ready_i=1 for 8 cycles, data 1..8 -> mem_wdata_o outputs 1..8 consecutively, count_o never exceeds 1.
REQ-037 Flush: count_o=2, flush_i=1 with ex_valid_i=1 data 0x33 -> next cycle count_o=0, mem_valid_o=0, 0x33 never appears.
REQ-038 Bubble: wreg=0, wd=7, wdata=0x5 -> mem_valid_o=1, mem_wreg_o=0, fwd_wreg_o=0.
REQ-039 Reset mid-operation: count_o=2, rst=1 one cycle -> all outputs 0, ex_ready_o=1, held beats never emitted.
